sensor_stream_mux: RTL and testbench

- Parametrised multi-channel sensor-to-UART stream aggregator. Sits between NUM_CH sensor sample sources (ADS1292 72-bit RDATAC frames, MPR121 touch status, future sensors) and the uart_controller TX interface.
- Buffers each channel in its own FIFO and arbitrates round-robin between channels.
- Frames each sample as a header word followed by TX_W-wide payload words, with a per-channel sequence number and a dropped-sample count.

---
 rtl/sensor_stream_mux.sv | 227 ++++++++++++++++++++++
 tb/tb_sensor_stream_mux.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_stream_mux.sv
// rtl/sensor_stream_mux.sv - per-channel sample FIFOs, round-robin arbiter and UART word framer
module sensor_stream_mux #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 72,
    parameter int TX_W       = 40,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic [NUM_CH*DATA_W-1:0] i_CH_DATA,
    input  logic [NUM_CH-1:0]        i_CH_VALID,
    input  logic [NUM_CH-1:0]        i_CH_ENABLE,
    input  logic                     i_CLR_STATUS,
    output logic [TX_W-1:0]          o_TX_DATA,
    output logic                     o_TX_VALID,
    input  logic                     i_TX_READY,
    output logic [NUM_CH-1:0]        o_CH_OVERFLOW,
    output logic                     o_BUSY
);

    localparam int N_WORDS = (DATA_W + TX_W - 1) / TX_W;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WIW     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int PW      = N_WORDS * TX_W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HDR     = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;

    logic [DATA_W-1:0] fifo_mem [NUM_CH][FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr   [NUM_CH];
    logic [AW-1:0]     rd_ptr   [NUM_CH];
    logic [CW-1:0]     count    [NUM_CH];
    logic [7:0]        drop_cnt [NUM_CH];
    logic [7:0]        seq      [NUM_CH];

    logic [1:0]        state;
    logic [CHW-1:0]    cur_ch;
    logic [CHW-1:0]    rr_ptr;
    logic [WIW-1:0]    word_idx;
    logic [DATA_W-1:0] holding;

    logic [NUM_CH-1:0] nonempty;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] wr_req;
    logic [NUM_CH-1:0] drop;
    logic [NUM_CH-1:0] wr_acc;
    logic              sel_found;
    logic [CHW-1:0]    sel_ch;
    logic [CHW:0]      rr_sum;
    logic              pop_en;
    logic              accept;
    logic              hdr_acc;
    logic              last_acc;

    // Header word: marker, channel, sequence, drops, word count, MSB-aligned in TX_W
    function automatic logic [TX_W-1:0] header_word(input logic [CHW-1:0] ch,
                                                    input logic [7:0] sq,
                                                    input logic [7:0] dc);
        logic [TX_W+39:0] wide;
        wide = {8'hA5, 8'(ch), sq, dc, 8'(N_WORDS), {TX_W{1'b0}}};
        return wide[TX_W+39 -: TX_W];
    endfunction

    // Payload word idx, MSB first, last word zero-padded in the LSBs
    function automatic logic [TX_W-1:0] payload_word(input logic [DATA_W-1:0] data,
                                                     input logic [WIW-1:0] idx);
        logic [PW-1:0] padded;
        logic [PW-1:0] shifted;
        padded  = PW'(data) << (PW - DATA_W);
        shifted = padded << (int'(idx) * TX_W);
        return shifted[PW-1 -: TX_W];
    endfunction

    // FIFO occupancy flags
    always_comb begin
        nonempty = '0;
        full     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            nonempty[k] = (count[k] != '0);
            full[k]     = (count[k] == CW'(FIFO_DEPTH));
        end
    end

    // Round-robin pick: first non-empty channel at or after rr_ptr
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        rr_sum    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rr_sum = {1'b0, rr_ptr} + (CHW+1)'(i);
            if (rr_sum >= (CHW+1)'(NUM_CH)) begin
                rr_sum = rr_sum - (CHW+1)'(NUM_CH);
            end
            if (!sel_found && nonempty[rr_sum[CHW-1:0]]) begin
                sel_found = 1'b1;
                sel_ch    = rr_sum[CHW-1:0];
            end
        end
    end

    assign pop_en   = (state == S_IDLE) && sel_found;
    assign accept   = o_TX_VALID && i_TX_READY;
    assign hdr_acc  = accept && (state == S_HDR);
    assign last_acc = accept && (state == S_PAYLOAD) && (word_idx == WIW'(N_WORDS - 1));

    // One-hot pop of the selected channel
    always_comb begin
        pop = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            pop[k] = pop_en && (sel_ch == CHW'(k));
        end
    end

    // A full FIFO still accepts a write when it is popped on the same edge
    assign wr_req = i_CH_VALID & i_CH_ENABLE;
    assign drop   = wr_req & full & ~pop;
    assign wr_acc = wr_req & ~drop;

    assign o_BUSY = (state != S_IDLE) || (|nonempty);

    // Sample storage; contents need no reset because pointers gate visibility
    always_ff @(posedge i_CLK) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (wr_acc[k]) begin
                fifo_mem[k][wr_ptr[k]] <= i_CH_DATA[k*DATA_W +: DATA_W];
            end
        end
    end

    // FIFO pointers and occupancy counters
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            for (int k = 0; k < NUM_CH; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_acc[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
                if (pop[k])    rd_ptr[k] <= rd_ptr[k] + 1'b1;
                if (wr_acc[k] && !pop[k]) begin
                    count[k] <= count[k] + 1'b1;
                end else if (!wr_acc[k] && pop[k]) begin
                    count[k] <= count[k] - 1'b1;
                end
            end
        end
    end

    // Per-channel sequence, saturating drop counters and sticky overflow flags
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_CH_OVERFLOW <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                seq[k]      <= '0;
                drop_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (hdr_acc && (cur_ch == CHW'(k))) begin
                    seq[k]      <= seq[k] + 8'd1;
                    drop_cnt[k] <= drop[k] ? 8'd1 : 8'd0;
                end else if (drop[k] && (drop_cnt[k] != 8'hFF)) begin
                    drop_cnt[k] <= drop_cnt[k] + 8'd1;
                end
                if (drop[k]) begin
                    o_CH_OVERFLOW[k] <= 1'b1;
                end else if (i_CLR_STATUS) begin
                    o_CH_OVERFLOW[k] <= 1'b0;
                end
            end
        end
    end

    // Packet framer: pop into holding, emit header then payload words
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state      <= S_IDLE;
            cur_ch     <= '0;
            rr_ptr     <= '0;
            word_idx   <= '0;
            holding    <= '0;
            o_TX_VALID <= 1'b0;
            o_TX_DATA  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        holding    <= fifo_mem[sel_ch][rd_ptr[sel_ch]];
                        cur_ch     <= sel_ch;
                        o_TX_DATA  <= header_word(sel_ch, seq[sel_ch], drop_cnt[sel_ch]);
                        o_TX_VALID <= 1'b1;
                        state      <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (hdr_acc) begin
                        word_idx  <= '0;
                        o_TX_DATA <= payload_word(holding, '0);
                        state     <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (last_acc) begin
                        o_TX_VALID <= 1'b0;
                        o_TX_DATA  <= '0;
                        rr_ptr     <= (cur_ch == CHW'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
                        state      <= S_IDLE;
                    end else if (accept) begin
                        word_idx  <= word_idx + 1'b1;
                        o_TX_DATA <= payload_word(holding, word_idx + 1'b1);
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    o_TX_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_stream_mux.sv
// tb/tb_sensor_stream_mux.sv - queue-model checked bench for sensor_stream_mux
module tb_sensor_stream_mux;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [143:0] ch_data = '0;
    logic [1:0]   ch_valid = '0;
    logic [1:0]   ch_enable = 2'b11;
    logic         clr = 1'b0;
    logic         ready = 1'b0;
    logic [39:0]  tx_data;
    logic         tx_valid;
    logic [1:0]   ovf;
    logic         busy;

    int checks = 0;
    int failures = 0;

    // Reference model: sample queues, outgoing word queue, per-channel counters
    logic [71:0] mq [2][$];
    logic [39:0] oq [$];
    logic [7:0]  m_seq [2];
    logic [7:0]  m_drop [2];
    logic [1:0]  m_ovf;
    int          m_rr;
    int          m_cur;
    logic [39:0] dut_log [$];

    sensor_stream_mux #(.NUM_CH(2), .DATA_W(72), .TX_W(40), .FIFO_DEPTH(4)) dut (
        .i_CLK(clk), .i_RST(rst), .i_CH_DATA(ch_data), .i_CH_VALID(ch_valid),
        .i_CH_ENABLE(ch_enable), .i_CLR_STATUS(clr), .o_TX_DATA(tx_data),
        .o_TX_VALID(tx_valid), .i_TX_READY(ready), .o_CH_OVERFLOW(ovf), .o_BUSY(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] hdr(input int ch, input logic [7:0] s, input logic [7:0] d);
        logic [7:0] c8;
        c8 = ch[7:0];
        return {8'hA5, c8, s, d, 8'h02};
    endfunction

    // Model update on each edge, from the rules: queue limit 4, RR pick, header/payload framing
    always @(posedge clk or posedge rst) begin
        int          pop_ch;
        logic [1:0]  wr;
        logic [1:0]  drp;
        logic        acc;
        logic        is_hdr;
        logic [39:0] hv;
        logic [79:0] pad;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                mq[c].delete();
                m_seq[c] = 8'd0;
                m_drop[c] = 8'd0;
            end
            oq.delete();
            m_rr = 0;
            m_cur = 0;
            m_ovf = 2'b00;
        end else begin
            pop_ch = -1;
            hv = '0;
            if (oq.size() == 0) begin
                for (int i = 0; i < 2; i++) begin
                    int c;
                    c = (m_rr + i) % 2;
                    if (pop_ch < 0 && mq[c].size() > 0) pop_ch = c;
                end
            end
            if (pop_ch >= 0) hv = hdr(pop_ch, m_seq[pop_ch], m_drop[pop_ch]);
            for (int c = 0; c < 2; c++) begin
                wr[c]  = ch_valid[c] & ch_enable[c];
                drp[c] = wr[c] && (mq[c].size() == 4) && (pop_ch != c);
            end
            acc = (oq.size() > 0) && ready;
            is_hdr = (oq.size() == 3);
            if (acc) begin
                if (is_hdr) begin
                    m_seq[m_cur] = m_seq[m_cur] + 8'd1;
                    m_drop[m_cur] = drp[m_cur] ? 8'd1 : 8'd0;
                end
                void'(oq.pop_front());
                if (oq.size() == 0) m_rr = (m_cur + 1) % 2;
            end
            for (int c = 0; c < 2; c++) begin
                if (drp[c] && !(acc && is_hdr && c == m_cur) && m_drop[c] != 8'hFF)
                    m_drop[c] = m_drop[c] + 8'd1;
                m_ovf[c] = drp[c] ? 1'b1 : (clr ? 1'b0 : m_ovf[c]);
            end
            if (pop_ch >= 0) begin
                pad = {mq[pop_ch].pop_front(), 8'h00};
                m_cur = pop_ch;
                oq.push_back(hv);
                oq.push_back(pad[79:40]);
                oq.push_back(pad[39:0]);
            end
            for (int c = 0; c < 2; c++) begin
                if (wr[c] && !drp[c]) mq[c].push_back(ch_data[c*72 +: 72]);
            end
        end
    end

    // Compare process: outputs against the model on every negedge out of reset
    always @(negedge clk) begin
        if (!rst) begin
            chk("tx_valid", tx_valid, oq.size() > 0);
            if (oq.size() > 0) chk("tx_data", tx_data, oq[0]);
            chk("overflow", ovf, m_ovf);
            chk("busy", busy, (oq.size() > 0) || (mq[0].size() > 0) || (mq[1].size() > 0));
            if (tx_valid && ready) dut_log.push_back(tx_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ch_valid = '0;
        clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        dut_log.delete();
    endtask

    task automatic strobe(input logic [1:0] m, input logic [71:0] d0, input logic [71:0] d1);
        ch_data = {d1, d0};
        ch_valid = m;
        tick();
        ch_valid = '0;
    endtask

    task automatic wait_log(input int n, input int budget);
        int k;
        k = 0;
        while (dut_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("wait_log", dut_log.size(), n);
    endtask

    localparam logic [71:0] SAMPLE = 72'h0123456789ABCDEF55;

    initial begin
        logic [39:0]  w;
        logic [39:0]  held;
        logic [159:0] r;

        // Single sample, latency and literal framing
        do_reset();
        ready = 1'b1;
        chk("reset_valid", tx_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_data", tx_data, 40'h0);
        strobe(2'b01, SAMPLE, '0);
        chk("latency_t", tx_valid, 1'b0);
        tick();
        chk("latency_t1", tx_valid, 1'b1);
        wait_log(3, 50);
        chk("single_hdr", dut_log[0], 40'hA500000002);
        chk("single_w0", dut_log[1], 40'h0123456789);
        chk("single_w1", dut_log[2], 40'hABCDEF5500);

        // Round-robin between two simultaneous channels
        do_reset();
        ready = 1'b1;
        strobe(2'b11, 72'h11, 72'h22);
        strobe(2'b11, 72'h33, 72'h44);
        wait_log(12, 100);
        chk("rr_hdr0", dut_log[0], 40'hA500000002);
        chk("rr_hdr1", dut_log[3], 40'hA501000002);
        chk("rr_hdr2", dut_log[6], 40'hA500010002);
        chk("rr_hdr3", dut_log[9], 40'hA501010002);
        chk("rr_pay1", dut_log[5], 40'h0000002200);

        // Backpressure during payload
        do_reset();
        ready = 1'b1;
        strobe(2'b01, SAMPLE, '0);
        wait_log(1, 50);
        ready = 1'b0;
        held = tx_data;
        repeat (20) tick();
        chk("bp_valid", tx_valid, 1'b1);
        chk("bp_hold", tx_data, held);
        ready = 1'b1;
        wait_log(3, 50);
        repeat (5) tick();
        chk("bp_count", dut_log.size(), 3);
        chk("bp_w0", dut_log[1], 40'h0123456789);
        chk("bp_w1", dut_log[2], 40'hABCDEF5500);

        // Overflow: ch0 packet stalled, ch1 strobed six times
        do_reset();
        ready = 1'b0;
        strobe(2'b01, SAMPLE, '0);
        tick();
        for (int i = 0; i < 6; i++) strobe(2'b10, '0, 72'(i + 1));
        chk("ovf_flag", ovf, 2'b10);
        ready = 1'b1;
        wait_log(15, 200);
        repeat (10) tick();
        chk("ovf_count", dut_log.size(), 15);
        chk("ovf_hdr_first", dut_log[3], 40'hA501000202);
        chk("ovf_pay_first", dut_log[5], 40'h0000000100);
        chk("ovf_hdr_next", dut_log[6], 40'hA501010002);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ovf_clear", ovf, 2'b00);

        // Sequence wrap with ch1 disabled but strobing
        do_reset();
        ready = 1'b1;
        ch_enable = 2'b01;
        for (int i = 0; i < 257; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom};
            strobe(2'b11, r[71:0], r[143:72]);
            repeat (4) tick();
        end
        wait_log(771, 100);
        repeat (10) tick();
        chk("wrap_count", dut_log.size(), 771);
        w = dut_log[765];
        chk("wrap_seq255", w[23:16], 8'hFF);
        w = dut_log[768];
        chk("wrap_seq0", w[23:16], 8'h00);
        chk("wrap_ch", w[31:24], 8'h00);
        chk("disable_ovf", ovf, 2'b00);
        ch_enable = 2'b11;

        // Reset in the middle of a payload
        do_reset();
        ready = 1'b0;
        strobe(2'b01, SAMPLE, '0);
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        chk("mid_valid_pre", tx_valid, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_valid_async", tx_valid, 1'b0);
        chk("mid_busy_async", busy, 1'b0);
        chk("mid_data_async", tx_data, 40'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dut_log.delete();
        ready = 1'b1;
        strobe(2'b01, SAMPLE, '0);
        wait_log(3, 50);
        chk("mid_new_hdr", dut_log[0], 40'hA500000002);

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom};
            ch_data = r[143:0];
            ch_valid = {($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30)};
            if ($urandom_range(0, 99) < 2) ch_enable = 2'($urandom_range(0, 3));
            ready = ($urandom_range(0, 99) < 70);
            clr = ($urandom_range(0, 99) < 5);
            tick();
        end
        ch_valid = '0;
        clr = 1'b0;
        ready = 1'b1;
        repeat (100) tick();
        chk("drain_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
